// File: rtl/dmem_if.sv
// Request/response channels between the core's load/store path and a data-memory responder.
interface dmem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory target: one outstanding load/store, LATENCY wait cycles, held response.
//   state | meaning
//   IDLE  | ready for a request
//   WAIT  | request latched, down-counting to the access edge
//   RESP  | result registered, holding until resp_ready
module dmem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic  clk,
    input  logic  rst,
    dmem_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t state, state_nxt;

    logic [3:0]    cnt;
    logic          we_q;
    logic [2:0]    f3_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   mem [DEPTH];

    logic          accept;
    logic          done;
    logic          resp_fire;
    logic          err;
    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic [31:0]   word;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [31:0]   load_val;
    logic [3:0]    be;
    logic [31:0]   wlanes;

    assign accept    = (state == IDLE) && bus.req_valid;
    assign done      = (state == WAIT) && (cnt == 4'd0);
    assign resp_fire = (state == RESP) && bus.resp_ready;
    assign idx       = addr_q[AW+1:2];
    assign lane      = addr_q[1:0];
    assign word      = mem[idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.req_valid)  state_nxt = WAIT;
            WAIT:    if (cnt == 4'd0)    state_nxt = RESP;
            RESP:    if (bus.resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        case (state)
            IDLE:    bus.req_ready  = 1'b1;
            RESP:    bus.resp_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= 4'd0;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
        end else if (accept) begin
            cnt     <= 4'(LATENCY - 1);
            we_q    <= bus.req_we;
            f3_q    <= bus.req_funct3;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
        end else if ((state == WAIT) && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
        end
    end

    // BU/HU are load-only; any address bit above the array is out of range
    always_comb begin
        err = 1'b0;
        case (f3_q)
            3'b000, 3'b100: err = 1'b0;
            3'b001, 3'b101: err = addr_q[0];
            3'b010:         err = (addr_q[1:0] != 2'b00);
            default:        err = 1'b1;
        endcase
        if (we_q && f3_q[2])           err = 1'b1;
        if (addr_q[31:AW+2] != '0)     err = 1'b1;
    end

    always_comb begin
        byte_sel = word[{lane, 3'b000} +: 8];
        half_sel = word[{lane[1], 4'b0000} +: 16];
        case (f3_q[1:0])
            2'b00:   load_val = {{24{byte_sel[7] & ~f3_q[2]}}, byte_sel};
            2'b01:   load_val = {{16{half_sel[15] & ~f3_q[2]}}, half_sel};
            default: load_val = word;
        endcase
    end

    always_comb begin
        case (f3_q[1:0])
            2'b00: begin
                be     = 4'b0001 << lane;
                wlanes = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be     = addr_q[1] ? 4'b1100 : 4'b0011;
                wlanes = {2{wdata_q[15:0]}};
            end
            default: begin
                be     = 4'b1111;
                wlanes = wdata_q;
            end
        endcase
    end

    // Contents survive reset; a reset in WAIT forces IDLE so no write commits
    always_ff @(posedge clk) begin
        if (done && we_q && !err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wlanes[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.resp_rdata <= 32'd0;
            bus.resp_err   <= 1'b0;
        end else if (done) begin
            bus.resp_rdata <= (we_q || err) ? 32'd0 : load_val;
            bus.resp_err   <= err;
        end else if (resp_fire) begin
            bus.resp_rdata <= 32'd0;
            bus.resp_err   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus random traffic against a byte-array model.
module tb_dmem_responder;
    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_er;
    } op_t;

    logic clk = 1'b0;
    logic rst;
    int   pass_cnt = 0;
    int   total = 0;
    logic [7:0] ref_mem [DEPTH*4];

    dmem_if bus();

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference: byte-addressed memory, width/sign from funct3, alignment by modulo
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] rd, output logic er);
        int size;
        bit sgn;
        longint unsigned v;
        er = 1'b0; rd = 32'd0; size = 0; sgn = 1'b0;
        case (f3)
            3'd0: begin size = 1; sgn = 1'b1; end
            3'd1: begin size = 2; sgn = 1'b1; end
            3'd2: size = 4;
            3'd4: size = 1;
            3'd5: size = 2;
            default: er = 1'b1;
        endcase
        if (we && f3 >= 3'd4) er = 1'b1;
        if (a >= 32'(DEPTH*4)) er = 1'b1;
        if (!er && (a % size) != 0) er = 1'b1;
        if (er) return;
        if (we) begin
            for (int i = 0; i < size; i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
        end else begin
            v = 0;
            for (int i = 0; i < size; i++) v += longint'(ref_mem[int'(a) + i]) << (8*i);
            if (sgn && v[8*size-1]) v = v - (longint'(1) << (8*size));
            rd = v[31:0];
        end
    endtask

    // Issue one request from just after a clock edge; returns data and edges from accept to resp_valid
    task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic rr,
                        output logic [31:0] rd, output logic er, output int lat);
        int w;
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
        bus.req_addr = addr; bus.req_wdata = wd; bus.resp_ready = rr;
        w = 0;
        while (bus.req_ready !== 1'b1 && w < 50) begin @(posedge clk); #1; w++; end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = -1; rd = 32'd0; er = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (bus.resp_valid === 1'b1) begin
                lat = i; rd = bus.resp_rdata; er = bus.resp_err;
                break;
            end
        end
        if (rr && lat > 0) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'd0;
        bus.req_addr = 32'd0; bus.req_wdata = 32'd0; bus.resp_ready = 1'b1;
        #12;
        total++; if (bus.req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b want 1", bus.req_ready); else pass_cnt++;
        total++; if (bus.resp_valid !== 1'b0) $display("FAIL reset_resp_valid: got %b want 0", bus.resp_valid); else pass_cnt++;
        total++; if (bus.resp_rdata !== 32'd0) $display("FAIL reset_rdata: got %h want 0", bus.resp_rdata); else pass_cnt++;
        total++; if (bus.resp_err !== 1'b0) $display("FAIL reset_err: got %b want 0", bus.resp_err); else pass_cnt++;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_init();
        logic [31:0] rd, erd, wd;
        logic er, eer;
        int lat;
        for (int w = 0; w < 64; w++) begin
            wd = $urandom;
            model(1'b1, 3'd2, 32'(w*4), wd, erd, eer);
            xact(1'b1, 3'd2, 32'(w*4), wd, 1'b1, rd, er, lat);
            total++;
            if (lat != LAT || er !== 1'b0 || rd !== 32'd0)
                $display("FAIL init_sw[%0d]: got lat=%0d err=%b rd=%h want lat=%0d err=0 rd=0", w, lat, er, rd, LAT);
            else pass_cnt++;
        end
    endtask

    task automatic test_word();
        op_t ops [2] = '{
            '{1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0},
            '{1'b0, 3'd2, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0}};
        logic [31:0] rd, mrd; logic er, mer; int lat;
        foreach (ops[i]) begin
            model(ops[i].we, ops[i].f3, ops[i].addr, ops[i].wd, mrd, mer);
            xact(ops[i].we, ops[i].f3, ops[i].addr, ops[i].wd, 1'b1, rd, er, lat);
            total++; if (lat != LAT) $display("FAIL word_latency[%0d]: got %0d want %0d", i, lat, LAT); else pass_cnt++;
            total++; if (rd !== ops[i].exp_rd || er !== ops[i].exp_er)
                $display("FAIL word[%0d]: got rd=%h err=%b want rd=%h err=%b", i, rd, er, ops[i].exp_rd, ops[i].exp_er);
            else pass_cnt++;
        end
    endtask

    task automatic test_byte();
        op_t ops [5] = '{
            '{1'b1, 3'd2, 32'h10, 32'h11223344, 32'h0,        1'b0},
            '{1'b1, 3'd0, 32'h11, 32'h000000A5, 32'h0,        1'b0},
            '{1'b0, 3'd0, 32'h11, 32'h0,        32'hFFFFFFA5, 1'b0},
            '{1'b0, 3'd4, 32'h11, 32'h0,        32'h000000A5, 1'b0},
            '{1'b0, 3'd2, 32'h10, 32'h0,        32'h1122A544, 1'b0}};
        logic [31:0] rd, mrd; logic er, mer; int lat;
        foreach (ops[i]) begin
            model(ops[i].we, ops[i].f3, ops[i].addr, ops[i].wd, mrd, mer);
            xact(ops[i].we, ops[i].f3, ops[i].addr, ops[i].wd, 1'b1, rd, er, lat);
            total++; if (lat != LAT || rd !== ops[i].exp_rd || er !== ops[i].exp_er)
                $display("FAIL byte[%0d]: got lat=%0d rd=%h err=%b want lat=%0d rd=%h err=%b",
                         i, lat, rd, er, LAT, ops[i].exp_rd, ops[i].exp_er);
            else pass_cnt++;
        end
    endtask

    task automatic test_half();
        op_t ops [6] = '{
            '{1'b1, 3'd1, 32'h12, 32'h00008001, 32'h0,        1'b0},
            '{1'b0, 3'd1, 32'h12, 32'h0,        32'hFFFF8001, 1'b0},
            '{1'b0, 3'd5, 32'h12, 32'h0,        32'h00008001, 1'b0},
            '{1'b0, 3'd4, 32'h10, 32'h0,        32'h00000044, 1'b0},
            '{1'b0, 3'd4, 32'h11, 32'h0,        32'h000000A5, 1'b0},
            '{1'b0, 3'd2, 32'h10, 32'h0,        32'h8001A544, 1'b0}};
        logic [31:0] rd, mrd; logic er, mer; int lat;
        foreach (ops[i]) begin
            model(ops[i].we, ops[i].f3, ops[i].addr, ops[i].wd, mrd, mer);
            xact(ops[i].we, ops[i].f3, ops[i].addr, ops[i].wd, 1'b1, rd, er, lat);
            total++; if (lat != LAT || rd !== ops[i].exp_rd || er !== ops[i].exp_er)
                $display("FAIL half[%0d]: got lat=%0d rd=%h err=%b want lat=%0d rd=%h err=%b",
                         i, lat, rd, er, LAT, ops[i].exp_rd, ops[i].exp_er);
            else pass_cnt++;
        end
    endtask

    task automatic test_errors();
        op_t ops [8] = '{
            '{1'b0, 3'd2, 32'h13,   32'h0,        32'h0,        1'b1},
            '{1'b1, 3'd1, 32'h11,   32'h0000FFFF, 32'h0,        1'b1},
            '{1'b0, 3'd3, 32'h10,   32'h0,        32'h0,        1'b1},
            '{1'b1, 3'd4, 32'h10,   32'h000000FF, 32'h0,        1'b1},
            '{1'b1, 3'd7, 32'h10,   32'hFFFFFFFF, 32'h0,        1'b1},
            '{1'b0, 3'd2, 32'h1000, 32'h0,        32'h0,        1'b1},
            '{1'b1, 3'd2, 32'h1000, 32'h12345678, 32'h0,        1'b1},
            '{1'b0, 3'd2, 32'h10,   32'h0,        32'h8001A544, 1'b0}};
        logic [31:0] rd, mrd; logic er, mer; int lat;
        foreach (ops[i]) begin
            model(ops[i].we, ops[i].f3, ops[i].addr, ops[i].wd, mrd, mer);
            xact(ops[i].we, ops[i].f3, ops[i].addr, ops[i].wd, 1'b1, rd, er, lat);
            total++; if (lat != LAT || rd !== ops[i].exp_rd || er !== ops[i].exp_er)
                $display("FAIL err[%0d]: got lat=%0d rd=%h err=%b want lat=%0d rd=%h err=%b",
                         i, lat, rd, er, LAT, ops[i].exp_rd, ops[i].exp_er);
            else pass_cnt++;
        end
    endtask

    task automatic test_hold();
        logic [31:0] rd; logic er; int lat;
        xact(1'b0, 3'd2, 32'h10, 32'h0, 1'b0, rd, er, lat);
        total++; if (lat != LAT || rd !== 32'h8001A544 || er !== 1'b0)
            $display("FAIL hold_first: got lat=%0d rd=%h err=%b want lat=%0d rd=8001a544 err=0", lat, rd, er, LAT);
        else pass_cnt++;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            total++;
            if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'h8001A544 || bus.resp_err !== 1'b0 || bus.req_ready !== 1'b0)
                $display("FAIL hold_stable[%0d]: got valid=%b rd=%h err=%b req_ready=%b want 1 8001a544 0 0",
                         c, bus.resp_valid, bus.resp_rdata, bus.resp_err, bus.req_ready);
            else pass_cnt++;
        end
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        total++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0)
            $display("FAIL hold_release: got req_ready=%b resp_valid=%b want 1 0", bus.req_ready, bus.resp_valid);
        else pass_cnt++;
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd, mrd; logic er, mer; int lat, w, seen;
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'd2;
        bus.req_addr = 32'h20; bus.req_wdata = 32'h55; bus.resp_ready = 1'b1;
        w = 0;
        while (bus.req_ready !== 1'b1 && w < 50) begin @(posedge clk); #1; w++; end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        rst = 1'b1;
        #1;
        total++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0)
            $display("FAIL abort_in_reset: got req_ready=%b resp_valid=%b want 1 0", bus.req_ready, bus.resp_valid);
        else pass_cnt++;
        @(negedge clk); rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (bus.resp_valid === 1'b1) seen++;
        end
        total++; if (seen != 0) $display("FAIL abort_no_resp: got %0d response cycles want 0", seen); else pass_cnt++;
        model(1'b0, 3'd2, 32'h20, 32'h0, mrd, mer);
        xact(1'b0, 3'd2, 32'h20, 32'h0, 1'b1, rd, er, lat);
        total++; if (lat != LAT || rd !== mrd || er !== 1'b0)
            $display("FAIL abort_word: got lat=%0d rd=%h err=%b want lat=%0d rd=%h err=0", lat, rd, er, LAT, mrd);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int acc[$];
        int w;
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'd2;
        bus.req_addr = 32'h10; bus.resp_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (bus.req_ready === 1'b1) acc.push_back(c);
            @(posedge clk); #1;
        end
        bus.req_valid = 1'b0;
        w = 0;
        while (bus.req_ready !== 1'b1 && w < 20) begin @(posedge clk); #1; w++; end
        total++; if (acc.size() < 4) $display("FAIL b2b_count: got %0d accepts want >= 4", acc.size()); else pass_cnt++;
        for (int i = 1; i < acc.size(); i++) begin
            total++;
            if (acc[i] - acc[i-1] != LAT + 2)
                $display("FAIL b2b_gap[%0d]: got %0d want %0d", i, acc[i] - acc[i-1], LAT + 2);
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, mrd, addr, wd; logic er, mer, we; logic [2:0] f3; int lat;
        for (int n = 0; n < 300; n++) begin
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            wd = $urandom;
            if ($urandom_range(0, 15) == 0) addr = 32'h1000 + 32'($urandom_range(0, 8191));
            else addr = 32'($urandom_range(0, 255));
            model(we, f3, addr, wd, mrd, mer);
            xact(we, f3, addr, wd, 1'b1, rd, er, lat);
            total++;
            if (lat != LAT || rd !== mrd || er !== mer)
                $display("FAIL rand[%0d] we=%b f3=%0d a=%h: got lat=%0d rd=%h err=%b want lat=%0d rd=%h err=%b",
                         n, we, f3, addr, lat, rd, er, LAT, mrd, mer);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_word();
        test_byte();
        test_half();
        test_errors();
        test_hold();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Handshaked data-memory target that services load/store requests from the core's datapath. It is the responder end of the core's data-memory access path.
- Each request carries address, store data and the RISC-V funct3 width code. The block completes byte, half and word stores with lane masking, and byte, half and word loads with sign or zero extension.
- Replaces the zero-wait-state memory so that multi-cycle memory timing can be modelled, with a ready/valid request channel and a ready/valid response channel.

Parameters:
- DEPTH, 1024, number of 32-bit words in the array; must be a power of two.
- LATENCY, 2, number of wait cycles between request acceptance and response; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  width code: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU are loads only).
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  output  1  response present.
- resp_ready  input  1  initiator accepts the response.
- resp_rdata  output  32  load result, already extended; 0 for stores and for errors.
- resp_err  output  1  request was misaligned, illegal or out of range.

Behaviour:
- Reset, applied asynchronously:
  - state = IDLE, wait counter = 0.
  - req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0.
  - Memory contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready, latch we, funct3, addr and wdata; load counter = LATENCY-1; go to WAIT.
- WAIT:
  - req_ready = 0; the counter decrements each cycle.
  - When the counter is 0, perform the access and go to RESP. resp_rdata and resp_err are registered on that same edge.
  - Result: request accepted at edge N gives resp_valid = 1 after edge N+LATENCY.
- RESP:
  - resp_valid = 1; resp_rdata and resp_err are held stable until resp_ready = 1.
  - When resp_valid & resp_ready are both 1 at an edge, clear resp_valid and return to IDLE.
  - req_ready stays 0 in RESP. A new request is accepted at the earliest on the cycle after the response handshake. One request is outstanding at a time.
- Addressing: word index = addr[log2(DEPTH)+1:2]; byte lane = addr[1:0].
- Error checks, with resp_err = 1, no memory write and resp_rdata = 0 when any applies:
  - H/HU with addr[0] = 1.
  - W with addr[1:0] != 00.
  - funct3 is 011, 110 or 111.
  - Store with funct3[2] = 1.
  - addr >= DEPTH*4.
- Stores:
  - SB writes wdata[7:0] to the addressed lane only.
  - SH writes wdata[15:0] to lanes {addr[1],0} and {addr[1],1}.
  - SW writes all four lanes.
  - Unaddressed lanes are unchanged.
  - The write commits only on the WAIT->RESP edge. Stores still produce a response with rdata = 0.
- Loads:
  - Select the lane(s) by addr[1:0].
  - B and H sign-extend from bit 7 or 15; BU and HU zero-extend; W returns the full word.
  - Byte order is little-endian (lane 0 = bits [7:0]).
- Reset mid-operation: any request in WAIT is aborted with no write committed; a pending response in RESP is discarded.
- req_* inputs are ignored outside IDLE. Requests arriving while req_ready = 0 are not latched; the initiator must hold them until accepted.
- resp_ready held at 1 gives back-to-back throughput of one request per LATENCY+2 cycles.

Test Plan:
- Reset, then SW addr 0x10 data 0xDEADBEEF, then LW 0x10 with LATENCY = 2 -> each resp_valid is asserted exactly 2 cycles after its accept edge; LW returns 0xDEADBEEF, resp_err = 0.
- SB 0x11 data 0x000000A5 onto word 0x11223344 at 0x10, then LB 0x11, LBU 0x11, LW 0x10 -> LB returns 0xFFFFFFA5, LBU 0x000000A5, LW 0x1122A544.
- SH 0x12 data 0x8001, then LH 0x12 and LHU 0x12 -> LH returns 0xFFFF8001, LHU 0x00008001; bytes at 0x10/0x11 are unchanged.
- LW 0x13, SH 0x11, funct3 011, SB with funct3 100, and LW at DEPTH*4 -> each gives resp_err = 1 and rdata = 0; a later LW of the targeted word shows no change.
- Hold resp_ready = 0 for 5 cycles after a load completes -> resp_valid, rdata and err stay stable and req_ready = 0 throughout; raising resp_ready returns the FSM to IDLE with req_ready = 1 on the next cycle.
- Issue SW 0x20 data 0x55, assert rst during WAIT, release, then LW 0x20 -> no response is produced for the aborted store, and the word still holds its pre-store value.
